// File: rtl/adc_spi_seq_capture.sv
// Serial ADC front end: generates CS/SCLK/MOSI, scans channels round-robin and
// captures MSB-first frames into a tagged result register with valid/ack handshake.
module adc_spi_seq_capture #(
   parameter int FRAME_BITS = 16,
   parameter int DATA_BITS  = 12,
   parameter int LEAD_BITS  = 4,
   parameter int NUM_CH     = 8,
   parameter int CH_W       = 3,
   parameter int CLK_DIV    = 2,
   parameter int QUIET      = 4,
   parameter int ADDR_POS   = 2,
   parameter int PIPE_ADDR  = 1
) (
   input  logic                 Clock_Muestreo,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 continuous,
   input  logic                 ack,
   input  logic                 clr_overrun,
   input  logic                 data_ADC,
   output logic                 adc_sclk,
   output logic                 CS,
   output logic                 adc_mosi,
   output logic                 busy,
   output logic                 done,
   output logic                 valid,
   output logic                 overrun,
   output logic [DATA_BITS-1:0] Dato,
   output logic [CH_W-1:0]      canal
);

   localparam int CNT_MAX = (2*CLK_DIV > QUIET) ? 2*CLK_DIV : QUIET;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(FRAME_BITS + 1);
   localparam int ADDR_SH = FRAME_BITS - ADDR_POS - CH_W;

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   // Address word is kept MSB-first: frame bit k sits at position FRAME_BITS-1-k.
   function automatic logic [FRAME_BITS-1:0] addr_word(input logic [CH_W-1:0] p);
      return {{(FRAME_BITS-CH_W){1'b0}}, p} << ADDR_SH;
   endfunction

   function automatic logic [DATA_BITS-1:0] frame_result(input logic [FRAME_BITS-1:0] f);
      return f[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
   endfunction

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic [BIT_W-1:0]      bitn;
   logic [CH_W-1:0]       ptr;
   logic [CH_W-1:0]       prev_ptr;
   logic                  dummy;
   logic [FRAME_BITS-1:0] shift_sr;
   logic [FRAME_BITS-1:0] mosi_sr;
   logic [FRAME_BITS-1:0] next_word;
   logic                  period_end;
   logic                  frame_end;
   logic                  load_res;

   assign next_word  = addr_word((state == IDLE) ? {CH_W{1'b0}} : ptr);
   assign period_end = (cnt == CNT_W'(2*CLK_DIV-1));
   assign frame_end  = (state == SHIFT) && period_end && (bitn == BIT_W'(FRAME_BITS-1));
   assign load_res   = frame_end && !dummy;

   always_ff @(posedge Clock_Muestreo or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bitn     <= '0;
         ptr      <= '0;
         prev_ptr <= '0;
         dummy    <= 1'b1;
         shift_sr <= '0;
         mosi_sr  <= '0;
         CS       <= 1'b1;
         adc_sclk <= 1'b1;
         adc_mosi <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
         Dato     <= '0;
         canal    <= '0;
      end else begin
         done <= load_res;
         if (load_res) begin
            Dato  <= frame_result(shift_sr);
            canal <= (PIPE_ADDR != 0) ? prev_ptr : ptr;
         end
         // A fresh result beats a same-cycle ack; a set beats a same-cycle clear.
         if (load_res)
            valid <= 1'b1;
         else if (ack)
            valid <= 1'b0;
         if (load_res && valid && !ack)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SETUP;
                  CS       <= 1'b0;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  ptr      <= '0;
                  dummy    <= (PIPE_ADDR != 0);
                  mosi_sr  <= next_word;
                  adc_mosi <= next_word[FRAME_BITS-1];
               end
            end
            SETUP: begin
               if (cnt == CNT_W'(CLK_DIV-1)) begin
                  state    <= SHIFT;
                  cnt      <= '0;
                  bitn     <= '0;
                  adc_sclk <= 1'b0;
                  adc_mosi <= mosi_sr[FRAME_BITS-1];
                  mosi_sr  <= mosi_sr << 1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == CNT_W'(CLK_DIV-1)) begin
                  adc_sclk <= 1'b1;
                  shift_sr <= {shift_sr[FRAME_BITS-2:0], data_ADC};
                  cnt      <= cnt + 1'b1;
               end else if (period_end) begin
                  cnt <= '0;
                  if (bitn == BIT_W'(FRAME_BITS-1)) begin
                     state    <= HOLD;
                     CS       <= 1'b1;
                     adc_mosi <= 1'b0;
                     dummy    <= 1'b0;
                     prev_ptr <= ptr;
                     ptr      <= (ptr == CH_W'(NUM_CH-1)) ? {CH_W{1'b0}} : ptr + 1'b1;
                  end else begin
                     bitn     <= bitn + 1'b1;
                     adc_sclk <= 1'b0;
                     adc_mosi <= mosi_sr[FRAME_BITS-1];
                     mosi_sr  <= mosi_sr << 1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(QUIET-1)) begin
                  cnt <= '0;
                  if (continuous) begin
                     state    <= SETUP;
                     CS       <= 1'b0;
                     mosi_sr  <= next_word;
                     adc_mosi <= next_word[FRAME_BITS-1];
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_spi_seq_capture.sv
// Bench for adc_spi_seq_capture: two instances (pipelined address / same-frame address
// at slower SCLK) driven by ADC models, with scoreboards checking every result.
module tb_adc_spi_seq_capture;

   localparam int PER = 10;

   logic clk = 1'b0;
   always #(PER/2) clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [2:0]  ch;
      logic [11:0] d;
   } res_t;

   res_t q_a[$];
   res_t q_b[$];

   // Instance A: default parameters (pipelined address, CLK_DIV=2)
   logic rst_a_n = 1'b0, st_a = 1'b0, cont_a = 1'b0, ack_a = 1'b0, clro_a = 1'b0, miso_a = 1'b0;
   logic sclk_a, cs_a, mosi_a, busy_a, done_a, valid_a, ovr_a;
   logic [11:0] dato_a;
   logic [2:0]  canal_a;

   adc_spi_seq_capture u_dut_a (
      .Clock_Muestreo(clk), .reset_n(rst_a_n), .start(st_a), .continuous(cont_a),
      .ack(ack_a), .clr_overrun(clro_a), .data_ADC(miso_a),
      .adc_sclk(sclk_a), .CS(cs_a), .adc_mosi(mosi_a), .busy(busy_a), .done(done_a),
      .valid(valid_a), .overrun(ovr_a), .Dato(dato_a), .canal(canal_a)
   );

   // Instance B: same-frame address, CLK_DIV=3
   logic rst_b_n = 1'b0, st_b = 1'b0, cont_b = 1'b0, ack_b = 1'b0, clro_b = 1'b0, miso_b = 1'b0;
   logic sclk_b, cs_b, mosi_b, busy_b, done_b, valid_b, ovr_b;
   logic [11:0] dato_b;
   logic [2:0]  canal_b;

   adc_spi_seq_capture #(.CLK_DIV(3), .PIPE_ADDR(0)) u_dut_b (
      .Clock_Muestreo(clk), .reset_n(rst_b_n), .start(st_b), .continuous(cont_b),
      .ack(ack_b), .clr_overrun(clro_b), .data_ADC(miso_b),
      .adc_sclk(sclk_b), .CS(cs_b), .adc_mosi(mosi_b), .busy(busy_b), .done(done_b),
      .valid(valid_b), .overrun(ovr_b), .Dato(dato_b), .canal(canal_b)
   );

   bit en_mdl = 1'b0;

   // ADC model A: echoes the channel received in the previous frame as 0xA50|ch
   int          frames_a = 0, k_a = 0, rises_a = 0;
   logic [15:0] word_a = '0, rx_a = '0;
   logic [2:0]  echo_a = '0, mptr_a = '0;

   always @(negedge cs_a) if (en_mdl) begin
      frames_a++;
      k_a     = 0;
      rises_a = 0;
      rx_a    = '0;
      word_a  = 16'h0A50 | {13'b0, echo_a};
      miso_a  = word_a[15];
   end
   always @(negedge sclk_a) if (en_mdl && !cs_a && k_a < 16) begin
      miso_a = word_a[15-k_a];
      k_a++;
   end
   always @(posedge sclk_a) if (en_mdl && !cs_a) begin
      rx_a = {rx_a[14:0], mosi_a};
      rises_a++;
   end
   always @(posedge cs_a) if (en_mdl && rises_a == 16) begin
      check("mosi_addr_a", 32'(rx_a), 32'({2'b00, mptr_a, 11'b0}));
      echo_a = rx_a[13:11];
      mptr_a++;
      rises_a = 0;
   end

   // ADC model B: returns word_b, and times CS/SCLK edges
   int          frames_b = 0, k_b = 0, rises_b = 0;
   logic [15:0] word_b = '0;
   time         t_edge_b = 0, t_rise_b = 0;

   always @(negedge cs_b) if (en_mdl) begin
      frames_b++;
      k_b      = 0;
      rises_b  = 0;
      miso_b   = word_b[15];
      if (t_rise_b > 0)
         check("cs_quiet_b", 32'(($time - t_rise_b) >= 4*PER), 32'd1);
      t_edge_b = $time;
   end
   always @(negedge sclk_b) if (en_mdl && !cs_b) begin
      check("sclk_half_lo_b", 32'($time - t_edge_b), 32'(3*PER));
      t_edge_b = $time;
      if (k_b < 16) begin
         miso_b = word_b[15-k_b];
         k_b++;
      end
   end
   always @(posedge sclk_b) if (en_mdl && !cs_b) begin
      check("sclk_half_hi_b", 32'($time - t_edge_b), 32'(3*PER));
      t_edge_b = $time;
      rises_b++;
   end
   always @(posedge cs_b) if (en_mdl && frames_b > 0) begin
      check("sclk_rises_b", 32'(rises_b), 32'd16);
      t_rise_b = $time;
   end

   // Scoreboard monitors: A acknowledges each result one cycle later, B never does
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         ack_a = 1'b0;
         if (done_a) begin
            ack_a = 1'b1;
            if (q_a.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL sb_a_extra: unexpected done canal=%0d Dato=%0h", canal_a, dato_a);
            end else begin
               e = q_a.pop_front();
               check("sb_a_canal", 32'(canal_a), 32'(e.ch));
               check("sb_a_dato", 32'(dato_a), 32'(e.d));
            end
         end
      end
   end

   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (done_b) begin
            if (q_b.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL sb_b_extra: unexpected done canal=%0d Dato=%0h", canal_b, dato_b);
            end else begin
               e = q_b.pop_front();
               check("sb_b_canal", 32'(canal_b), 32'(e.ch));
               check("sb_b_dato", 32'(dato_b), 32'(e.d));
            end
         end
      end
   end

   task automatic push_a(input logic [2:0] ch, input logic [11:0] d);
      res_t e;
      e.ch = ch;
      e.d  = d;
      q_a.push_back(e);
   endtask

   task automatic push_b(input logic [2:0] ch, input logic [11:0] d);
      res_t e;
      e.ch = ch;
      e.d  = d;
      q_b.push_back(e);
   endtask

   task automatic pulse_a;
      @(negedge clk) st_a = 1'b1;
      @(negedge clk) st_a = 1'b0;
   endtask

   task automatic pulse_b;
      @(negedge clk) st_b = 1'b1;
      @(negedge clk) st_b = 1'b0;
   endtask

   task automatic wait_idle_a(input string nm, input int maxc);
      int n = 0;
      while (busy_a && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(busy_a), 32'd0);
   endtask

   task automatic wait_idle_b(input string nm, input int maxc);
      int n = 0;
      while (busy_b && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(busy_b), 32'd0);
   endtask

   task automatic wait_frames_a(input string nm, input int target, input int maxc);
      int n = 0;
      while (frames_a < target && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(frames_a >= target), 32'd1);
   endtask

   task automatic wait_k_a(input string nm, input int target, input int maxc);
      int n = 0;
      while (k_a < target && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(nm, 32'(k_a >= target), 32'd1);
   endtask

   task automatic check_reset_a(input string nm);
      check(nm, 32'({cs_a, sclk_a, mosi_a, busy_a, done_a, valid_a, ovr_a, dato_a, canal_a}),
            32'({2'b11, 20'b0}));
   endtask

   initial begin
      int n;
      int base;
      res_t e;

      // Reset state
      repeat (3) @(negedge clk);
      check_reset_a("reset_a");
      check("reset_b", 32'({cs_b, sclk_b, mosi_b, busy_b, done_b, valid_b, ovr_b, dato_b, canal_b}),
            32'({2'b11, 20'b0}));
      en_mdl  = 1'b1;
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single-shot, same-frame address: latency and result
      word_b = 16'h0ABC;
      push_b(3'd0, 12'hABC);
      st_b = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) st_b = 1'b0;
      end while (!done_b && n < 300);
      check("t1_done_latency", 32'(n), 32'd100);
      check("t1_valid", 32'(valid_b), 32'd1);
      while (busy_b && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      check("t1_busy_latency", 32'(n), 32'd104);
      @(negedge clk) ack_b = 1'b1;
      @(negedge clk) ack_b = 1'b0;
      check("t1_valid_acked", 32'(valid_b), 32'd0);

      // Continuous at CLK_DIV=3 with ack held: timing checked in model B
      word_b = 16'h1234;
      push_b(3'd0, 12'h234);
      push_b(3'd1, 12'h234);
      ack_b  = 1'b1;
      cont_b = 1'b1;
      base   = frames_b;
      pulse_b();
      n = 0;
      while (frames_b < base + 2 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("t3_frames_b", 32'(frames_b), 32'(base + 2));
      cont_b = 1'b0;
      wait_idle_b("t3_idle_b", 300);
      ack_b = 1'b0;
      check("t3_no_overrun", 32'(ovr_b), 32'd0);
      @(negedge clk) ack_b = 1'b1;
      @(negedge clk) ack_b = 1'b0;

      // Overrun on unacknowledged result, then clear
      word_b = 16'hF5A5;
      push_b(3'd0, 12'h5A5);
      pulse_b();
      wait_idle_b("t4_idle1", 300);
      check("t4_valid1", 32'(valid_b), 32'd1);
      check("t4_ovr1", 32'(ovr_b), 32'd0);
      push_b(3'd0, 12'h5A5);
      pulse_b();
      wait_idle_b("t4_idle2", 300);
      check("t4_ovr2", 32'(ovr_b), 32'd1);
      @(negedge clk) clro_b = 1'b1;
      @(negedge clk) clro_b = 1'b0;
      check("t4_ovr_cleared", 32'(ovr_b), 32'd0);

      // done and ack in the same cycle while valid=1
      push_b(3'd0, 12'h5A5);
      @(negedge clk) st_b = 1'b1;
      n = 0;
      while (n < 100) begin
         @(posedge clk); #1;
         n++;
         if (n == 1) st_b = 1'b0;
         if (n == 99) ack_b = 1'b1;
      end
      ack_b = 1'b0;
      check("t4_done_ack_done", 32'(done_b), 32'd1);
      check("t4_done_ack_valid", 32'(valid_b), 32'd1);
      check("t4_done_ack_ovr", 32'(ovr_b), 32'd0);
      wait_idle_b("t4_idle3", 300);
      @(negedge clk) ack_b = 1'b1;
      @(negedge clk) ack_b = 1'b0;

      // Continuous, pipelined address: 10 frames, first is dummy
      mptr_a = '0;
      base   = frames_a;
      for (int i = 0; i < 9; i++)
         push_a(3'(i % 8), 12'hA50 | 12'(i % 8));
      cont_a = 1'b1;
      pulse_a();
      wait_frames_a("t2_frames", base + 10, 900);
      cont_a = 1'b0;
      wait_idle_a("t2_idle", 200);
      check("t2_frame_count", 32'(frames_a), 32'(base + 10));
      check("t2_drained", 32'(q_a.size()), 32'd0);

      // Continuous dropped at bit 5 of frame 2; start while busy ignored
      mptr_a = '0;
      base   = frames_a;
      push_a(3'd0, 12'hA50);
      cont_a = 1'b1;
      pulse_a();
      wait_frames_a("t6_frame2", base + 2, 200);
      wait_k_a("t6_bit5", 6, 100);
      cont_a = 1'b0;
      pulse_a();
      wait_idle_a("t6_idle", 200);
      repeat (150) @(negedge clk);
      check("t6_stays_idle", 32'(busy_a), 32'd0);
      check("t6_frame_count", 32'(frames_a), 32'(base + 2));
      check("t6_drained", 32'(q_a.size()), 32'd0);

      // Reset mid-frame at bit 7, then a clean frame from channel 0
      mptr_a = '0;
      base   = frames_a;
      pulse_a();
      wait_frames_a("t5_frame", base + 1, 100);
      wait_k_a("t5_bit7", 8, 100);
      rst_a_n = 1'b0;
      #1;
      check_reset_a("t5_reset_now");
      @(negedge clk);
      check_reset_a("t5_reset_held");
      rst_a_n = 1'b1;
      @(negedge clk);
      mptr_a = '0;
      pulse_a();
      wait_idle_a("t5_idle", 200);
      check("t5_frames", 32'(frames_a), 32'(base + 2));
      check("t5_mosi_ptr_adv", 32'(mptr_a), 32'd1);
      check("t5_no_result", 32'(valid_a), 32'd0);

      repeat (5) @(negedge clk);
      check("final_drained_a", 32'(q_a.size()), 32'd0);
      check("final_drained_b", 32'(q_b.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #(PER * 40000);
      $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule
